// File: rtl/screen_seq_ctrl.sv
// Frame-synchronous screen sequencer: start -> play -> win banner -> start, with saturating win tallies.
// Optional banner blink in win screens is enabled by defining SCREEN_SEQ_BLINK_EN.
module screen_seq_ctrl #(
  parameter int WIN_FRAMES   = 180,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start_btn,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic [1:0] screen_sel,
  output logic       game_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       banner_on
);

  if (WIN_FRAMES < 1 || WIN_FRAMES > 4095) begin : g_bad_win_frames
    $error("WIN_FRAMES must be in 1..4095");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
    $error("BLINK_FRAMES must be in 1..255");
  end

  localparam logic [11:0] WIN_LAST = 12'(WIN_FRAMES - 1);

  // Encodings double as the overlay mux select.
  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_PLAY   = 2'd1,
    S_P1_WON = 2'd2,
    S_P2_WON = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        vblnk_q, start_q;
  logic        frame_tick, start_pulse;
  logic        start_pend, skip_pend;
  logic [1:0]  win_pend;
  logic [11:0] frame_cnt;
  logic        in_win;

  assign frame_tick  = vblnk & ~vblnk_q;
  assign start_pulse = start_btn & ~start_q;
  assign in_win      = (state == S_P1_WON) || (state == S_P2_WON);

  // Only registered pending flags are consulted, so a request arriving on a tick waits one frame.
  always_comb begin
    state_nxt = state;
    if (frame_tick) begin
      case (state)
        S_START: if (start_pend) state_nxt = S_PLAY;
        S_PLAY: begin
          if (win_pend == 2'd1)      state_nxt = S_P1_WON;
          else if (win_pend == 2'd2) state_nxt = S_P2_WON;
        end
        default: if (skip_pend || frame_cnt == WIN_LAST) state_nxt = S_START;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_START;
      screen_sel <= 2'd0;
      game_en    <= 1'b0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      vblnk_q    <= 1'b0;
      start_q    <= 1'b0;
      start_pend <= 1'b0;
      skip_pend  <= 1'b0;
      win_pend   <= 2'd0;
      frame_cnt  <= 12'd0;
    end else begin
      vblnk_q    <= vblnk;
      start_q    <= start_btn;
      state      <= state_nxt;
      screen_sel <= state_nxt;
      game_en    <= (state_nxt == S_PLAY);
      case (state)
        S_START: begin
          if (frame_tick && start_pend) start_pend <= 1'b0;
          else if (start_pulse)         start_pend <= 1'b1;
        end
        S_PLAY: begin
          if (frame_tick && win_pend != 2'd0) begin
            win_pend <= 2'd0;
            if (win_pend == 2'd1 && p1_score != 4'd15) p1_score <= p1_score + 4'd1;
            if (win_pend == 2'd2 && p2_score != 4'd15) p2_score <= p2_score + 4'd1;
          end else if (win_pend == 2'd0) begin
            if (p1_win)      win_pend <= 2'd1;
            else if (p2_win) win_pend <= 2'd2;
          end
        end
        default: begin
          // Clearing on exit leaves frame_cnt at zero for the next win entry.
          if (state_nxt != state) begin
            frame_cnt <= 12'd0;
            skip_pend <= 1'b0;
          end else begin
            if (frame_tick)  frame_cnt <= frame_cnt + 12'd1;
            if (start_pulse) skip_pend <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SCREEN_SEQ_BLINK_EN
  logic [7:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= 8'd0;
      banner_on <= 1'b1;
    end else if (in_win && state_nxt == state) begin
      if (frame_tick) begin
        if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
          blink_cnt <= 8'd0;
          banner_on <= ~banner_on;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end else begin
      blink_cnt <= 8'd0;
      banner_on <= 1'b1;
    end
  end
`else
  logic unused_in_win;
  assign unused_in_win = in_win;
  assign banner_on     = 1'b1;
`endif

endmodule

// File: doc/screen_seq_ctrl.md
Name: screen_seq_ctrl

Overview:
- Top-level screen sequencer for the game display. Decides which full-screen overlay drives the VGA pipeline: start, play field, "PLAYER 1 WON" or "PLAYER 2 WON".
- Emits a registered screen select for the overlay mux, a game-enable for the gameplay logic, and per-player win tallies.
- Screen changes take effect only at a frame boundary (rising edge of vblnk) so there is no tearing mid-frame.

Parameters:
- WIN_FRAMES, 180, number of frame ticks a win screen is held before returning to start (legal range 1..4095).
- BLINK_FRAMES, 30, frame ticks per half-period of the banner blink (optional feature only; legal range 1..255).

Ports:
- clk  in  1  pixel clock, same as the VGA timing chain.
- rst  in  1  asynchronous, active-high reset.
- vblnk  in  1  vertical blank from the timing generator.
- start_btn  in  1  start button, already synchronised, level.
- p1_win  in  1  player-1 win pulse from game logic, valid in PLAY only.
- p2_win  in  1  player-2 win pulse from game logic, valid in PLAY only.
- screen_sel  out  2  0=start, 1=play, 2=P1 won, 3=P2 won.
- game_en  out  1  high only while in PLAY.
- p1_score  out  4  saturating P1 win count.
- p2_score  out  4  saturating P2 win count.
- banner_on  out  1  win-banner visibility for the overlay.

Behaviour:
- Reset: all flops are cleared asynchronously.
  - state=S_START, screen_sel=0, game_en=0, p1_score=p2_score=0, banner_on=1.
  - All pending flags and counters=0, vblnk_q=0, start_q=0.
- frame_tick:
  - = vblnk & ~vblnk_q, with vblnk_q registered each clk.
  - One cycle wide, once per frame.
- start_pulse:
  - = start_btn & ~start_q, with start_q registered.
  - A held button produces exactly one pulse.
- Pending requests:
  - Requests are latched into sticky flags and applied on the next frame_tick.
  - Flags are cleared on the same clk edge that applies them.
- States and transitions (all transitions occur on the clk edge where frame_tick=1):
  - S_START → S_PLAY when start_pend=1. start_pend is set by start_pulse in S_START.
  - S_PLAY → S_P1_WON if win_pend=P1; → S_P2_WON if win_pend=P2.
    - win_pend latches the first win pulse seen in S_PLAY; later pulses are ignored until it is applied.
    - p1_win and p2_win in the same cycle: P1 wins.
    - The matching score increments on the transition edge. At 15 it holds at 15 (no wrap).
  - S_P1_WON / S_P2_WON:
    - frame_cnt (12 bit) is cleared on entry and increments on each frame_tick.
    - → S_START on the frame_tick where frame_cnt == WIN_FRAMES-1.
    - start_pulse in a win state sets skip_pend; the next frame_tick goes to S_START early.
- Ignored inputs:
  - p1_win/p2_win outside S_PLAY.
  - start_btn outside S_START and the win states.
  - A start_pulse and a frame_tick in the same cycle: the pulse is latched and applied on the following frame_tick, not the current one.
- Outputs are registered from the next-state value, so screen_sel and game_en change on the same edge as state. game_en=1 only in S_PLAY.
- Scores persist across games; only rst clears them.
- An asserted rst at any point returns everything to reset values immediately, including mid-frame and mid-win-screen.
- No frame_tick (vblnk stuck): state holds indefinitely and requests stay pending.

Optional Feature:
- Macro SCREEN_SEQ_BLINK_EN.
- Defined:
  - In win states, an 8-bit blink counter counts frame_ticks.
  - banner_on toggles each time the counter reaches BLINK_FRAMES-1; the counter then reloads to 0.
  - On entry to a win state, banner_on=1 and the counter is 0.
  - In other states, banner_on=1.
- Not defined: banner_on is tied to 1 and no blink counter exists.

Test Plan:
- Reset then release, 3 frames with no inputs → screen_sel=0, game_en=0, scores 0, banner_on=1.
- start_btn held high for 1000 cycles mid-frame → exactly one transition; screen_sel=1 and game_en=1 on the first frame_tick edge after the press; nothing changes before that tick.
- In PLAY, p1_win and p2_win pulsed the same cycle → at the next frame_tick screen_sel=2, p1_score=1, p2_score=0, game_en=0.
- WIN_FRAMES=4 in a P2 win state → screen_sel=3 for exactly 4 frame_ticks, returns to 0 on the 4th tick edge; a start_pulse after the 1st tick returns to 0 on the 2nd tick.
- 16 consecutive P1 wins → p1_score saturates at 15 and stays 15 on the 17th win.
- rst asserted during a win screen with frame_cnt=2 → all outputs are reset values in the same cycle, with no clk edge required. With SCREEN_SEQ_BLINK_EN and BLINK_FRAMES=2, banner_on toggles on every 2nd frame_tick in a win state.
